// File: rtl/prog_seq_pkg.sv
// rtl/prog_seq_pkg.sv - shared opcodes, instruction field positions and state encoding
package prog_seq_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_JUMP  = 2'b11;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 14;
  localparam int REG_MSB  = 13;
  localparam int REG_LSB  = 10;
  localparam int MODE_MSB = 9;
  localparam int MODE_LSB = 8;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [7:0] instr_imm(input logic [15:0] instr);
    return instr[IMM_MSB:IMM_LSB];
  endfunction

endpackage

// File: rtl/prog_seq_if.sv
// rtl/prog_seq_if.sv - control, ROM and datapath-strobe bundle of the program sequencer
interface prog_seq_if;

  logic        start;
  logic        pause;
  logic [15:0] instr;
  logic [7:0]  pc_addr;
  logic        busy;
  logic        done;
  logic        err;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [3:0]  rf_raddr;
  logic        acc_load;
  logic [1:0]  alu_mode;
  logic [7:0]  imm;
  logic [7:0]  step_cnt;

  modport master (
    input  start, pause, instr,
    output pc_addr, busy, done, err, rf_we, rf_waddr, rf_raddr,
           acc_load, alu_mode, imm, step_cnt
  );

  modport slave (
    output start, pause, instr,
    input  pc_addr, busy, done, err, rf_we, rf_waddr, rf_raddr,
           acc_load, alu_mode, imm, step_cnt
  );

endinterface

// File: rtl/prog_seq_instr_decode.sv
// rtl/prog_seq_instr_decode.sv - combinational instruction decode, outputs zero unless en
module prog_seq_instr_decode
  import prog_seq_pkg::*;
(
  input  logic        en,
  input  logic [15:0] instr,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [3:0]  rf_raddr,
  output logic        acc_load,
  output logic [1:0]  alu_mode,
  output logic [7:0]  imm,
  output logic        is_jump
);

  logic [1:0] op;
  assign op = instr[OP_MSB:OP_LSB];

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 4'd0;
    rf_raddr = 4'd0;
    acc_load = 1'b0;
    alu_mode = 2'd0;
    imm      = 8'd0;
    is_jump  = 1'b0;
    if (en) begin
      case (op)
        OP_STORE: begin
          rf_we    = 1'b1;
          rf_waddr = instr[REG_MSB:REG_LSB];
        end
        OP_LOAD: begin
          acc_load = 1'b1;
          rf_raddr = instr[REG_MSB:REG_LSB];
          alu_mode = instr[MODE_MSB:MODE_LSB];
          imm      = instr[IMM_MSB:IMM_LSB];
        end
        OP_JUMP: is_jump = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/prog_seq.sv
// rtl/prog_seq.sv - program sequencer: fetch/exec loop over the instruction ROM with watchdog
module prog_seq
  import prog_seq_pkg::*;
#(
  parameter int PC_START  = 1,
  parameter int LAST_ADDR = 15,
  parameter int MAX_STEPS = 255
) (
  input  logic         clk,
  input  logic         rst,
  prog_seq_if.master   bus
);

  state_t     state, state_nxt;
  logic [7:0] pc_q, pc_nxt;
  logic [7:0] step_q, step_nxt;
  logic       err_q, err_nxt;

  logic       is_jump;
  logic [7:0] step_inc;
  logic [7:0] next_pc;
  logic       in_range;

  prog_seq_instr_decode u_decode (
    .en       (state == EXEC),
    .instr    (bus.instr),
    .rf_we    (bus.rf_we),
    .rf_waddr (bus.rf_waddr),
    .rf_raddr (bus.rf_raddr),
    .acc_load (bus.acc_load),
    .alu_mode (bus.alu_mode),
    .imm      (bus.imm),
    .is_jump  (is_jump)
  );

  // 8-bit PC arithmetic: wrap to 0 falls below PC_START and ends the run
  assign step_inc = step_q + 8'd1;
  assign next_pc  = is_jump ? instr_imm(bus.instr) : pc_q + 8'd1;
  assign in_range = (next_pc >= 8'(PC_START)) && (next_pc <= 8'(LAST_ADDR));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc_q   <= 8'd0;
      step_q <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc_q   <= pc_nxt;
      step_q <= step_nxt;
      err_q  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    step_nxt  = step_q;
    err_nxt   = err_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          pc_nxt    = 8'(PC_START);
          step_nxt  = 8'd0;
          err_nxt   = 1'b0;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (!bus.pause) state_nxt = EXEC;
      end
      EXEC: begin
        step_nxt = step_inc;
        // watchdog wins over the range check
        if (step_inc == 8'(MAX_STEPS)) begin
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else if (!in_range) begin
          state_nxt = DONE;
        end else begin
          pc_nxt    = next_pc;
          state_nxt = FETCH;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.pc_addr  = pc_q;
  assign bus.busy     = (state == FETCH) || (state == EXEC);
  assign bus.done     = (state == DONE);
  assign bus.err      = err_q;
  assign bus.step_cnt = step_q;

endmodule

// File: tb/tb_prog_seq.sv
// tb/tb_prog_seq.sv - self-checking bench: decode vector table, directed programs, random programs vs cycle model
module tb_prog_seq;

  localparam int PC_START  = 1;
  localparam int LAST_ADDR = 15;
  localparam int MAX_STEPS = 255;

  typedef struct packed {
    logic [7:0] pc_addr;
    logic       busy;
    logic       done;
    logic       err;
    logic       rf_we;
    logic [3:0] rf_waddr;
    logic [3:0] rf_raddr;
    logic       acc_load;
    logic [1:0] alu_mode;
    logic [7:0] imm;
    logic [7:0] step_cnt;
  } out_t;

  typedef struct {
    bit   start;
    bit   pause;
    bit   swap;
    out_t o;
  } cyc_t;

  typedef struct {
    logic [15:0] instr;
    logic        rf_we;
    logic [3:0]  waddr;
    logic [3:0]  raddr;
    logic        acc_load;
    logic [1:0]  mode;
    logic [7:0]  imm;
    int          steps;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [15:0] rom [0:15];
  int errors = 0;
  int checks = 0;
  cyc_t tr[$];
  vec_t vt[11];

  prog_seq_if bus();

  prog_seq #(
    .PC_START  (PC_START),
    .LAST_ADDR (LAST_ADDR),
    .MAX_STEPS (MAX_STEPS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // registered ROM, 1-cycle latency, address 0 and >15 read zero
  always @(posedge clk)
    bus.instr <= (bus.pc_addr >= 8'd1 && bus.pc_addr <= 8'd15) ? rom[bus.pc_addr[3:0]] : 16'h0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic out_t sample();
    out_t o;
    o.pc_addr  = bus.pc_addr;
    o.busy     = bus.busy;
    o.done     = bus.done;
    o.err      = bus.err;
    o.rf_we    = bus.rf_we;
    o.rf_waddr = bus.rf_waddr;
    o.rf_raddr = bus.rf_raddr;
    o.acc_load = bus.acc_load;
    o.alu_mode = bus.alu_mode;
    o.imm      = bus.imm;
    o.step_cnt = bus.step_cnt;
    return o;
  endfunction

  function automatic bit pick(input int mode);
    if (mode == 2) return 1'b1;
    if (mode == 1) return 1'($urandom_range(0, 1));
    return 1'b0;
  endfunction

  function automatic out_t exec_out(input int pc, input int steps, input int w);
    out_t o = '0;
    o.pc_addr  = 8'(pc);
    o.busy     = 1'b1;
    o.step_cnt = 8'(steps);
    if (w / 16384 == 1) begin
      o.rf_we    = 1'b1;
      o.rf_waddr = 4'((w / 1024) % 16);
    end else if (w / 16384 == 2) begin
      o.acc_load = 1'b1;
      o.rf_raddr = 4'((w / 1024) % 16);
      o.alu_mode = 2'((w / 256) % 4);
      o.imm      = 8'(w % 256);
    end
    return o;
  endfunction

  // cycle-by-cycle expectation of one run, derived from the instruction rules
  task automatic build_trace(input int start_mode, input bit rnd_pause,
                             input int pause_pc, input int pause_len, input bit prio);
    int pc = PC_START;
    int steps = 0;
    int np, w, nxt;
    bit e = 0, fin = 0, paused = 0;
    int m[16];
    cyc_t c;
    for (int a = 0; a < 16; a++) m[a] = int'(rom[a]);
    tr.delete();
    while (!fin) begin
      c.o = '0;
      c.o.pc_addr  = 8'(pc);
      c.o.busy     = 1'b1;
      c.o.step_cnt = 8'(steps);
      c.swap = 1'b0;
      if (prio && steps == MAX_STEPS - 1 && pc == 5) begin
        c.swap = 1'b1;
        m[5] = 32'hC000;
      end
      np = 0;
      if (pc == pause_pc && !paused) begin
        np = pause_len;
        paused = 1'b1;
      end else if (rnd_pause && $urandom_range(0, 3) == 0) begin
        np = int'($urandom_range(1, 3));
      end
      for (int i = 0; i <= np; i++) begin
        c.pause = (i < np);
        c.start = pick(start_mode);
        tr.push_back(c);
        c.swap = 1'b0;
      end
      w = m[pc];
      c.o = exec_out(pc, steps, w);
      c.pause = rnd_pause ? 1'($urandom_range(0, 1)) : 1'b0;
      c.start = pick(start_mode);
      tr.push_back(c);
      steps++;
      nxt = (w / 16384 == 3) ? (w % 256) : ((pc + 1) % 256);
      if (steps == MAX_STEPS) begin
        e = 1'b1;
        fin = 1'b1;
      end else if (nxt < PC_START || nxt > LAST_ADDR) begin
        fin = 1'b1;
      end else begin
        pc = nxt;
      end
    end
    c.o = '0;
    c.o.pc_addr  = 8'(pc);
    c.o.done     = 1'b1;
    c.o.err      = e;
    c.o.step_cnt = 8'(steps);
    c.pause = rnd_pause;
    c.start = pick(start_mode);
    c.swap  = 1'b0;
    tr.push_back(c);
    c.o.done = 1'b0;
    c.start  = 1'b0;
    tr.push_back(c);
  endtask

  task automatic run_trace(input string name);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < tr.size(); k++) begin
      if (tr[k].swap) rom[5] = 16'hC000;
      bus.start = tr[k].start;
      bus.pause = tr[k].pause;
      @(negedge clk);
      chk($sformatf("%s[%0d]", name, k), 64'(sample()), 64'(tr[k].o));
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.pause = 1'b0;
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 16; a++) rom[a] = 16'h0000;
  endtask

  task automatic load_prog1();
    clear_rom();
    rom[1] = 16'h8002;
    rom[2] = 16'h4400;
    rom[3] = 16'h8003;
    rom[4] = 16'h4800;
  endtask

  task automatic wait_done(input string name, output bit seen);
    int n = 0;
    while (!bus.done && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    seen = bus.done;
    chk({name, "_done_seen"}, 64'(bus.done), 64'd1);
  endtask

  initial begin
    bit seen;
    logic [15:0] w;
    int op;

    vt[0]  = '{16'h8002, 0, 4'h0, 4'h0, 1, 2'd0, 8'h02, 15,  0};
    vt[1]  = '{16'h4400, 1, 4'h1, 4'h0, 0, 2'd0, 8'h00, 15,  0};
    vt[2]  = '{16'hBEA5, 0, 4'h0, 4'hF, 1, 2'd2, 8'hA5, 15,  0};
    vt[3]  = '{16'h7FFF, 1, 4'hF, 4'h0, 0, 2'd0, 8'h00, 15,  0};
    vt[4]  = '{16'h3FFF, 0, 4'h0, 4'h0, 0, 2'd0, 8'h00, 15,  0};
    vt[5]  = '{16'hC00F, 0, 4'h0, 4'h0, 0, 2'd0, 8'h00, 2,   0};
    vt[6]  = '{16'hC010, 0, 4'h0, 4'h0, 0, 2'd0, 8'h00, 1,   0};
    vt[7]  = '{16'hC000, 0, 4'h0, 4'h0, 0, 2'd0, 8'h00, 1,   0};
    vt[8]  = '{16'hC001, 0, 4'h0, 4'h0, 0, 2'd0, 8'h00, 255, 1};
    vt[9]  = '{16'hC002, 0, 4'h0, 4'h0, 0, 2'd0, 8'h00, 15,  0};
    vt[10] = '{16'hC0FF, 0, 4'h0, 4'h0, 0, 2'd0, 8'h00, 1,   0};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    clear_rom();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", 64'(sample()), 64'd0);
    @(posedge clk); #1;

    // single-instruction decode table, instruction at PC1, rest NOP
    for (int i = 0; i < 11; i++) begin
      clear_rom();
      rom[1] = vt[i].instr;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("vec%0d_exec", i),
          64'({bus.rf_we, bus.rf_waddr, bus.rf_raddr, bus.acc_load, bus.alu_mode, bus.imm}),
          64'({vt[i].rf_we, vt[i].waddr, vt[i].raddr, vt[i].acc_load, vt[i].mode, vt[i].imm}));
      wait_done($sformatf("vec%0d", i), seen);
      chk($sformatf("vec%0d_end", i), 64'({bus.step_cnt, bus.err}), 64'({8'(vt[i].steps), vt[i].err}));
      @(posedge clk); #1;
    end

    load_prog1();
    build_trace(0, 0, 0, 0, 0);
    run_trace("prog1");

    load_prog1();
    rom[3] = 16'hC006;
    build_trace(0, 0, 0, 0, 0);
    run_trace("jump6");

    load_prog1();
    rom[5] = 16'hC001;
    build_trace(0, 0, 0, 0, 0);
    run_trace("watchdog");

    load_prog1();
    build_trace(0, 0, 2, 3, 0);
    run_trace("pause_pc2");

    load_prog1();
    rom[5] = 16'hC001;
    build_trace(0, 0, 0, 0, 1);
    run_trace("wd_priority");

    load_prog1();
    build_trace(2, 0, 0, 0, 0);
    run_trace("start_ignored");

    // reset during EXEC of PC4
    load_prog1();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_pre_exec4", 64'({bus.pc_addr, bus.rf_we, bus.rf_waddr}), 64'({8'd4, 1'b1, 4'd2}));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_run", 64'(sample()), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_no_done%0d", i), 64'({bus.done, bus.busy}), 64'd0);
    end
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("rst_restart", 64'({bus.pc_addr, bus.busy}), 64'({8'd1, 1'b1}));
    wait_done("rst_restart", seen);
    chk("rst_restart_steps", 64'(bus.step_cnt), 64'd15);
    @(posedge clk); #1;

    // random programs with random pause/start activity
    for (int r = 0; r < 20; r++) begin
      clear_rom();
      for (int a = 1; a < 16; a++) begin
        op = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
        w = 16'($urandom) & 16'h3FFF;
        w = w | 16'(op << 14);
        if (op == 3) w = (w & 16'hFF00) | 16'($urandom_range(0, 17));
        rom[a] = w;
      end
      build_trace(1, 1, 0, 0, 0);
      run_trace($sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
